// File: rtl/ofdm_pkg.sv
// Shared OFDM transmit definitions: default widths, buffer state encoding
// and the QPSK constellation helper used by the mapper.
package ofdm_pkg;

  localparam int DW  = 16;
  localparam int NSC = 64;
  localparam int AMP = 11585;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  // Wide signed pair; callers size-cast to their sample width.
  typedef struct packed {
    logic signed [31:0] i;
    logic signed [31:0] q;
  } iq_pair_t;

  // Gray QPSK: bit1 -> I sign, bit0 -> Q sign, 1 means negative.
  function automatic iq_pair_t qpsk_map(
    input logic [1:0] dibit,
    input int         amp = AMP
  );
    iq_pair_t r;
    r.i = dibit[1] ? -amp : amp;
    r.q = dibit[0] ? -amp : amp;
    return r;
  endfunction

endpackage

// File: rtl/skid_buf.sv
// Two-entry skid buffer, valid/ready on both sides, registered outputs.
// Ports: in_data/in_valid/in_ready upstream, out_data/out_valid/out_ready down.
module skid_buf #(
  parameter int W = 2 * ofdm_pkg::DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  import ofdm_pkg::*;

  buf_state_e   state;
  buf_state_e   state_nx;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         in_xfer;
  logic         out_xfer;
  logic         ld_main_in;
  logic         ld_main_skid;
  logic         ld_skid;

  // ready depends on registered state only, never on out_ready
  assign in_ready  = (state != BUF_TWO);
  assign out_valid = (state != BUF_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign out_data  = main_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= BUF_EMPTY;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      BUF_EMPTY: begin
        if (in_xfer) state_nx = BUF_ONE;
      end
      BUF_ONE: begin
        if (in_xfer && !out_xfer)      state_nx = BUF_TWO;
        else if (!in_xfer && out_xfer) state_nx = BUF_EMPTY;
      end
      BUF_TWO: begin
        if (out_xfer) state_nx = BUF_ONE;
      end
      default: state_nx = BUF_EMPTY;
    endcase
  end

  always_comb begin
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      BUF_EMPTY: ld_main_in = in_xfer;
      BUF_ONE: begin
        ld_main_in = in_xfer & out_xfer;
        ld_skid    = in_xfer & ~out_xfer;
      end
      BUF_TWO: ld_main_skid = out_xfer;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main_in)        main_q <= in_data;
      else if (ld_main_skid) main_q <= skid_q;
      if (ld_skid)           skid_q <= in_data;
    end
  end

endmodule

// File: rtl/qam_mapper.sv
// QPSK mapper and subcarrier framer: dibits in, signed I/Q with sop/eop out.
// Ports: en/data_in/valid_in/ready_out upstream; i_out/q_out/valid_out/ready_in/sop/eop down.
module qam_mapper #(
  parameter int DW  = ofdm_pkg::DW,
  parameter int AMP = ofdm_pkg::AMP,
  parameter int NSC = ofdm_pkg::NSC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           data_in,
  input  logic                 valid_in,
  output logic                 ready_out,
  output logic signed [DW-1:0] i_out,
  output logic signed [DW-1:0] q_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 sop,
  output logic                 eop
);
  import ofdm_pkg::*;

  localparam int SCW = $clog2(NSC);
  localparam logic [SCW-1:0] SC_LAST = SCW'(NSC - 1);

  iq_pair_t              map_w;
  logic signed [DW-1:0]  map_i;
  logic signed [DW-1:0]  map_q;
  logic                  buf_ready;
  logic [2*DW-1:0]       buf_data;
  logic [SCW-1:0]        sc;

  // map ahead of the buffer so it stores finished samples
  always_comb begin
    map_w = qpsk_map(data_in, AMP);
    map_i = DW'(map_w.i);
    map_q = DW'(map_w.q);
  end

  skid_buf #(
    .W(2 * DW)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({map_i, map_q}),
    .in_valid  (valid_in & en),
    .in_ready  (buf_ready),
    .out_data  (buf_data),
    .out_valid (valid_out),
    .out_ready (ready_in)
  );

  assign ready_out      = en & buf_ready;
  assign {i_out, q_out} = buf_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sc <= '0;
    end else if (valid_out && ready_in) begin
      sc <= (sc == SC_LAST) ? '0 : sc + 1'b1;
    end
  end

  assign sop = valid_out & (sc == '0);
  assign eop = valid_out & (sc == SC_LAST);

endmodule

// File: tb/tb_qam_mapper.sv
// Directed and randomized self-checking bench for qam_mapper.
// Covers reset, mapping, framing, backpressure, enable gating and reset flush.
module tb_qam_mapper;

  localparam logic [15:0] POS = 16'd11585;
  localparam logic [15:0] NEG = 16'hD2BF;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [1:0]         data_in;
  logic               valid_in;
  logic               ready_out;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               valid_out;
  logic               ready_in;
  logic               sop;
  logic               eop;

  int errors = 0;
  int checks = 0;

  logic [31:0] sb[$];
  int          bsc;
  logic        in_x;
  logic        out_x;
  logic [31:0] exp_iq;

  qam_mapper dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .i_out     (i_out),
    .q_out     (q_out),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .sop       (sop),
    .eop       (eop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mapx(input logic [1:0] d);
    logic [15:0] ei;
    logic [15:0] eq;
    ei = d[1] ? NEG : POS;
    eq = d[0] ? NEG : POS;
    return {ei, eq};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    rst = 1'b0; en = 1'b1; valid_in = 1'b0;
    ready_in = 1'b1; data_in = 2'b00;
    step; step;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_iq", {i_out, q_out}, 32'd0);
    chk("rst_sop", 32'(sop), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready_out), 32'd1);

    // four constellation points, one cycle latency each
    valid_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_in = 2'(k);
      step;
      chk("map_valid", 32'(valid_out), 32'd1);
      chk("map_iq", {i_out, q_out}, mapx(2'(k)));
      chk("map_sop", 32'(sop), 32'(k == 0));
    end
    valid_in = 1'b0;
    step;
    chk("map_idle", 32'(valid_out), 32'd0);

    // 128 back-to-back samples after a fresh reset
    rst = 1'b0; #1; rst = 1'b1;
    valid_in = 1'b1;
    for (int n = 0; n < 128; n++) begin
      data_in = 2'((n * 7) >> 1);
      step;
      chk("str_valid", 32'(valid_out), 32'd1);
      chk("str_iq", {i_out, q_out}, mapx(2'((n * 7) >> 1)));
      chk("str_sop", 32'(sop), 32'((n % 64) == 0));
      chk("str_eop", 32'(eop), 32'((n % 64) == 63));
    end
    valid_in = 1'b0;
    step;
    chk("str_idle", 32'(valid_out), 32'd0);

    // backpressure: two accepted, hold, then ordered drain
    valid_in = 1'b1; data_in = 2'b01; ready_in = 1'b0;
    #1;
    chk("bp_rdy0", 32'(ready_out), 32'd1);
    step;
    chk("bp_iqA", {i_out, q_out}, mapx(2'b01));
    chk("bp_rdy1", 32'(ready_out), 32'd1);
    chk("bp_sop", 32'(sop), 32'd1);
    data_in = 2'b10;
    step;
    chk("bp_rdy2", 32'(ready_out), 32'd0);
    chk("bp_hold1", {i_out, q_out}, mapx(2'b01));
    data_in = 2'b11;
    step; step;
    chk("bp_rdy3", 32'(ready_out), 32'd0);
    chk("bp_hold2", {i_out, q_out}, mapx(2'b01));
    ready_in = 1'b1;
    step;
    chk("bp_iqB", {i_out, q_out}, mapx(2'b10));
    chk("bp_rdy4", 32'(ready_out), 32'd1);
    chk("bp_sopB", 32'(sop), 32'd0);
    step;
    chk("bp_iqC", {i_out, q_out}, mapx(2'b11));
    valid_in = 1'b0;
    step;
    chk("bp_empty", 32'(valid_out), 32'd0);

    // enable low: buffered word drains, nothing accepted
    valid_in = 1'b1; data_in = 2'b00; ready_in = 1'b0;
    step;
    en = 1'b0; ready_in = 1'b1; data_in = 2'b11;
    #1;
    chk("en_rdy0", 32'(ready_out), 32'd0);
    chk("en_held", {i_out, q_out}, mapx(2'b00));
    step;
    chk("en_drain", 32'(valid_out), 32'd0);
    chk("en_rdy1", 32'(ready_out), 32'd0);
    step;
    chk("en_noacc", 32'(valid_out), 32'd0);
    en = 1'b1;
    #1;
    chk("en_rdy2", 32'(ready_out), 32'd1);
    step;
    chk("en_valid", 32'(valid_out), 32'd1);
    chk("en_iq", {i_out, q_out}, mapx(2'b11));
    valid_in = 1'b0;
    step;

    // reset while two words are held
    ready_in = 1'b0; valid_in = 1'b1; data_in = 2'b01;
    step;
    data_in = 2'b10;
    step;
    chk("rt_full", 32'(ready_out), 32'd0);
    chk("rt_valid", 32'(valid_out), 32'd1);
    rst = 1'b0;
    #1;
    chk("rt_v0", 32'(valid_out), 32'd0);
    chk("rt_iq0", {i_out, q_out}, 32'd0);
    chk("rt_sop0", 32'(sop), 32'd0);
    step;
    rst = 1'b1;
    #1;
    chk("rt_rdy", 32'(ready_out), 32'd1);
    ready_in = 1'b1; data_in = 2'b10;
    step;
    chk("rt_sop1", 32'(sop), 32'd1);
    chk("rt_iq1", {i_out, q_out}, mapx(2'b10));
    valid_in = 1'b0;
    step;

    // random handshakes against a queue model
    rst = 1'b0; #1; rst = 1'b1;
    bsc = 0;
    for (int c = 0; c < 700; c++) begin
      if (c < 650) begin
        valid_in = 1'($urandom_range(0, 1));
        ready_in = 1'($urandom_range(0, 1));
      end else begin
        valid_in = 1'b0;
        ready_in = 1'b1;
      end
      data_in = 2'($urandom);
      #1;
      in_x  = valid_in & ready_out;
      out_x = valid_out & ready_in;
      chk("rnd_rdy", 32'(ready_out), 32'(sb.size() < 2));
      chk("rnd_vld", 32'(valid_out), 32'(sb.size() != 0));
      if (out_x) begin
        exp_iq = (sb.size() != 0) ? sb[0] : 32'hxxxx_xxxx;
        chk("rnd_iq", {i_out, q_out}, exp_iq);
        chk("rnd_sop", 32'(sop), 32'(bsc == 0));
        chk("rnd_eop", 32'(eop), 32'(bsc == 63));
        if (sb.size() != 0) void'(sb.pop_front());
        bsc = (bsc == 63) ? 0 : bsc + 1;
      end
      if (in_x) sb.push_back(mapx(data_in));
      @(posedge clk);
      #1;
    end
    chk("rnd_drain", 32'(sb.size()), 32'd0);
    chk("rnd_idle", 32'(valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
